// File: rtl/operand_collector_4_if.sv
// Operand-collector bus: allocation from register allocation, bank read
// returns from the four-bank FIFO stage, free map, dispatch handshake.
interface operand_collector_4_if #(
  parameter int NUM_OC = 4,
  parameter int DATA_W = 256,
  parameter int TAG_W  = 8
);
  logic              alloc_valid;
  logic [3:0]        alloc_ocid;
  logic              alloc_src1_valid, alloc_src2_valid;
  logic [1:0]        alloc_src1_bank, alloc_src2_bank;
  logic [TAG_W-1:0]  alloc_tag;

  logic              rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3;
  logic [3:0]        rd_ocid_0, rd_ocid_1, rd_ocid_2, rd_ocid_3;
  logic [DATA_W-1:0] rd_data_0, rd_data_1, rd_data_2, rd_data_3;

  logic [NUM_OC-1:0] oc_free;
  logic              alloc_err;

  logic              disp_valid, disp_ready;
  logic [3:0]        disp_ocid;
  logic [TAG_W-1:0]  disp_tag;
  logic [DATA_W-1:0] disp_src1, disp_src2;

  // upstream / execution side
  modport master (
    output alloc_valid, alloc_ocid, alloc_src1_valid, alloc_src2_valid,
           alloc_src1_bank, alloc_src2_bank, alloc_tag,
           rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3,
           rd_ocid_0, rd_ocid_1, rd_ocid_2, rd_ocid_3,
           rd_data_0, rd_data_1, rd_data_2, rd_data_3,
           disp_ready,
    input  oc_free, alloc_err, disp_valid, disp_ocid, disp_tag,
           disp_src1, disp_src2
  );

  // collector side
  modport slave (
    input  alloc_valid, alloc_ocid, alloc_src1_valid, alloc_src2_valid,
           alloc_src1_bank, alloc_src2_bank, alloc_tag,
           rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3,
           rd_ocid_0, rd_ocid_1, rd_ocid_2, rd_ocid_3,
           rd_data_0, rd_data_1, rd_data_2, rd_data_3,
           disp_ready,
    output oc_free, alloc_err, disp_valid, disp_ocid, disp_tag,
           disp_src1, disp_src2
  );
endinterface

// File: rtl/operand_collector_4.sv
// Operand-collector array: one entry per OCID captures bank read data for
// its source operands, then a round-robin arbiter dispatches READY entries.
// Optional macro OC_BYPASS_EN: when nothing is READY, an entry completing
// this cycle may be offered in the same cycle with the arriving data.

// One collector entry: FREE -> COLLECT -> READY -> FREE.
module operand_collector_4_entry #(
  parameter int DATA_W    = 256,
  parameter int TAG_W     = 8,
  parameter int NUM_BANKS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_en,
  input  logic                             alloc_src1_valid,
  input  logic                             alloc_src2_valid,
  input  logic [1:0]                       alloc_src1_bank,
  input  logic [1:0]                       alloc_src2_bank,
  input  logic [TAG_W-1:0]                 alloc_tag,
  input  logic [NUM_BANKS-1:0]             rd_hit,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0] rd_data,
  input  logic                             take,
  output logic                             is_free,
  output logic                             is_ready,
  output logic                             is_byp,
  output logic [TAG_W-1:0]                 tag,
  output logic [DATA_W-1:0]                src1_view,
  output logic [DATA_W-1:0]                src2_view
);
  typedef enum logic [1:0] {FREE = 2'd0, COLLECT = 2'd1, READY = 2'd2} state_e;

  state_e            state, state_nxt;
  logic              need1, need2, need1_nxt, need2_nxt;
  logic              hit1, hit2, completing;
  logic [1:0]        bank1, bank2;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] src1, src2, src1_nxt, src2_nxt;

  // Capture: a shared bank fills src1 first, so src2 waits while src1 is pending.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (state == COLLECT) begin
      hit1 = need1 && rd_hit[bank1];
      hit2 = need2 && rd_hit[bank2] && !(need1 && bank1 == bank2);
    end
    need1_nxt  = need1 && !hit1;
    need2_nxt  = need2 && !hit2;
    src1_nxt   = hit1 ? rd_data[bank1] : src1;
    src2_nxt   = hit2 ? rd_data[bank2] : src2;
    completing = (state == COLLECT) && !need1_nxt && !need2_nxt;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FREE;
    else      state <= state_nxt;
  end

  // Next state; take in COLLECT only happens for a bypassed dispatch.
  always_comb begin
    state_nxt = state;
    case (state)
      FREE:    if (alloc_en)
                 state_nxt = (alloc_src1_valid || alloc_src2_valid) ? COLLECT : READY;
      COLLECT: if (take)            state_nxt = FREE;
               else if (completing) state_nxt = READY;
      READY:   if (take)            state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  // Outputs; bypass view exposes this cycle's captured data.
  always_comb begin
    is_free  = (state == FREE);
    is_ready = (state == READY);
`ifdef OC_BYPASS_EN
    is_byp    = completing;
    src1_view = (state == COLLECT) ? src1_nxt : src1;
    src2_view = (state == COLLECT) ? src2_nxt : src2;
`else
    is_byp    = 1'b0;
    src1_view = src1;
    src2_view = src2;
`endif
  end

  assign tag = tag_q;

  // Operand bookkeeping and data registers; allocation clears stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      need1 <= 1'b0;
      need2 <= 1'b0;
      bank1 <= '0;
      bank2 <= '0;
      tag_q <= '0;
      src1  <= '0;
      src2  <= '0;
    end else if (alloc_en) begin
      need1 <= alloc_src1_valid;
      need2 <= alloc_src2_valid;
      bank1 <= alloc_src1_bank;
      bank2 <= alloc_src2_bank;
      tag_q <= alloc_tag;
      src1  <= '0;
      src2  <= '0;
    end else begin
      need1 <= need1_nxt;
      need2 <= need2_nxt;
      src1  <= src1_nxt;
      src2  <= src2_nxt;
    end
  end
endmodule

module operand_collector_4 #(
  parameter int NUM_OC = 4,
  parameter int DATA_W = 256,
  parameter int TAG_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_collector_4_if.slave bus
);
  localparam int NUM_BANKS = 4;
  localparam int OCW       = (NUM_OC > 1) ? $clog2(NUM_OC) : 1;

  logic [NUM_BANKS-1:0]             rd_valid;
  logic [NUM_BANKS-1:0][3:0]        rd_ocid;
  logic [NUM_BANKS-1:0][DATA_W-1:0] rd_data;

  logic [NUM_OC-1:0]                alloc_en, take, is_free, is_ready, is_byp;
  logic [NUM_OC-1:0][NUM_BANKS-1:0] rd_hit;
  logic [NUM_OC-1:0][TAG_W-1:0]     tag;
  logic [NUM_OC-1:0][DATA_W-1:0]    src1_view, src2_view;

  logic [OCW-1:0] ptr, sel;
  logic [OCW:0]   pick;
  logic           sel_vld, accept, alloc_err_q;

  assign rd_valid = {bus.rd_valid_3, bus.rd_valid_2, bus.rd_valid_1, bus.rd_valid_0};
  assign rd_ocid  = {bus.rd_ocid_3,  bus.rd_ocid_2,  bus.rd_ocid_1,  bus.rd_ocid_0};
  assign rd_data  = {bus.rd_data_3,  bus.rd_data_2,  bus.rd_data_1,  bus.rd_data_0};

  genvar i, b;
  generate
    for (i = 0; i < NUM_OC; i++) begin : g_oc
      assign alloc_en[i] = bus.alloc_valid && bus.alloc_ocid == 4'(i) && is_free[i];
      assign take[i]     = accept && sel == OCW'(i);
      for (b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign rd_hit[i][b] = rd_valid[b] && rd_ocid[b] == 4'(i);
      end
      operand_collector_4_entry #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_BANKS(NUM_BANKS)
      ) u_entry (
        .clk              (clk),
        .rst              (rst),
        .alloc_en         (alloc_en[i]),
        .alloc_src1_valid (bus.alloc_src1_valid),
        .alloc_src2_valid (bus.alloc_src2_valid),
        .alloc_src1_bank  (bus.alloc_src1_bank),
        .alloc_src2_bank  (bus.alloc_src2_bank),
        .alloc_tag        (bus.alloc_tag),
        .rd_hit           (rd_hit[i]),
        .rd_data          (rd_data),
        .take             (take[i]),
        .is_free          (is_free[i]),
        .is_ready         (is_ready[i]),
        .is_byp           (is_byp[i]),
        .tag              (tag[i]),
        .src1_view        (src1_view[i]),
        .src2_view        (src2_view[i])
      );
    end
  endgenerate

  // First set bit of vec at or after start (wrapping); MSB = found.
  function automatic logic [OCW:0] rr_pick(input logic [NUM_OC-1:0] vec,
                                           input logic [OCW-1:0]    start);
    logic [OCW:0] r;
    int           j;
    r = '0;
    for (int k = NUM_OC - 1; k >= 0; k--) begin
      j = (int'(start) + k) % NUM_OC;
      if (vec[j]) r = {1'b1, OCW'(j)};
    end
    return r;
  endfunction

  // Arbitration: READY entries first, bypass candidates only if none READY.
  always_comb begin
    pick = rr_pick(is_ready, ptr);
    if (!pick[OCW]) pick = rr_pick(is_byp, ptr);
    sel_vld = pick[OCW];
    sel     = pick[OCW-1:0];
  end

  assign accept = sel_vld && bus.disp_ready;

  // Dispatch view; zero when nothing is offered.
  always_comb begin
    bus.disp_valid = sel_vld;
    bus.disp_ocid  = '0;
    bus.disp_tag   = '0;
    bus.disp_src1  = '0;
    bus.disp_src2  = '0;
    if (sel_vld) begin
      bus.disp_ocid = 4'(sel);
      bus.disp_tag  = tag[sel];
      bus.disp_src1 = src1_view[sel];
      bus.disp_src2 = src2_view[sel];
    end
  end

  // Pointer: advance past a granted entry; while stalled, park on the offered
  // entry so a newly READY entry earlier in the search order cannot displace it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr <= '0;
    else if (accept)  ptr <= OCW'((int'(sel) + 1) % NUM_OC);
    else if (sel_vld) ptr <= sel;
  end

  // Sticky error for allocations that land on a busy or nonexistent entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   alloc_err_q <= 1'b0;
    else if (bus.alloc_valid && !(|alloc_en))   alloc_err_q <= 1'b1;
  end

  assign bus.oc_free   = is_free;
  assign bus.alloc_err = alloc_err_q;
endmodule
